// File: rtl/snax_mac_job_seq.sv
// snax_mac_job_seq: job sequencer between the SNAX request stream and the HWPE MAC periph port.
// Accepts a whole job (register image + tag), writes the registers into the engine, fires the
// trigger, waits for the engine event and returns tag/status/cycle count on the done stream.
// Optional watchdog: define SNAX_MAC_SEQ_TIMEOUT_EN to end WAIT after TimeoutCycles with status TIMEOUT.
module snax_mac_job_seq #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned NumRegs       = 8,
    parameter logic [31:0] RegBase       = 32'h40,
    parameter logic [31:0] TrigAddr      = 32'h00,
    parameter int unsigned IdWidth       = 5,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           job_valid_i,
    output logic                           job_ready_o,
    input  logic [NumRegs*DataWidth-1:0]   job_regs_i,
    input  logic [7:0]                     job_tag_i,
    output logic                           done_valid_o,
    input  logic                           done_ready_i,
    output logic [7:0]                     done_tag_o,
    output logic [1:0]                     done_status_o,
    output logic [31:0]                    done_cycles_o,
    output logic                           periph_req_o,
    input  logic                           periph_gnt_i,
    output logic [31:0]                    periph_add_o,
    output logic                           periph_wen_o,
    output logic [3:0]                     periph_be_o,
    output logic [DataWidth-1:0]           periph_data_o,
    output logic [IdWidth-1:0]             periph_id_o,
    input  logic                           periph_r_valid_i,
    input  logic                           evt_i,
    output logic                           busy_o
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PROG = 3'd1;
    localparam logic [2:0] TRIG = 3'd2;
    localparam logic [2:0] WAIT = 3'd3;
    localparam logic [2:0] RESP = 3'd4;

    localparam logic [1:0] StatusOk      = 2'd0;
    localparam logic [1:0] StatusTimeout = 2'd1;

    localparam int unsigned KW    = (NumRegs > 1) ? $clog2(NumRegs) : 1;
    localparam logic [KW-1:0] LastK = KW'(NumRegs - 1);

`ifdef SNAX_MAC_SEQ_TIMEOUT_EN
    localparam logic [31:0] TimeoutLast  = 32'(TimeoutCycles - 1);
    localparam logic [31:0] TimeoutValue = 32'(TimeoutCycles);
`endif

    logic [2:0]           state_q;
    logic [KW-1:0]        k_q;
    logic [31:0]          cnt_q;
    logic [31:0]          cycles_q;
    logic [1:0]           status_q;
    logic [7:0]           tag_q;
    logic [DataWidth-1:0] regs_q [NumRegs];
    logic                 unused_sig;

    // Saturating increment for the engine cycle counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

`ifdef SNAX_MAC_SEQ_TIMEOUT_EN
    assign unused_sig = periph_r_valid_i;
`else
    assign unused_sig = periph_r_valid_i ^ (TimeoutCycles == 0);
`endif

    // Control path: job FSM, register index, cycle counter and completion record.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            k_q      <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
            status_q <= StatusOk;
        end else begin
            case (state_q)
                IDLE: begin
                    if (job_valid_i) begin
                        k_q     <= '0;
                        state_q <= PROG;
                    end
                end
                PROG: begin
                    if (periph_gnt_i) begin
                        if (k_q == LastK) state_q <= TRIG;
                        else              k_q     <= k_q + 1'b1;
                    end
                end
                TRIG: begin
                    if (periph_gnt_i) begin
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // The event cycle itself is part of the reported count.
                    if (evt_i) begin
                        cycles_q <= sat_inc(cnt_q);
                        status_q <= StatusOk;
                        state_q  <= RESP;
                    end
`ifdef SNAX_MAC_SEQ_TIMEOUT_EN
                    else if (cnt_q == TimeoutLast) begin
                        cycles_q <= TimeoutValue;
                        status_q <= StatusTimeout;
                        state_q  <= RESP;
                    end
`endif
                    else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                RESP: begin
                    if (done_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data path: capture the job image and tag on acceptance; outputs are gated by state.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && job_valid_i) begin
            tag_q <= job_tag_i;
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= job_regs_i[i*DataWidth +: DataWidth];
            end
        end
    end

    // Output decode: everything derives from state so reset forces outputs to idle values at once.
    always_comb begin
        job_ready_o   = (state_q == IDLE);
        busy_o        = (state_q != IDLE);
        done_valid_o  = (state_q == RESP);
        done_tag_o    = '0;
        done_status_o = '0;
        done_cycles_o = '0;
        periph_req_o  = 1'b0;
        periph_add_o  = '0;
        periph_data_o = '0;
        periph_be_o   = 4'h0;
        periph_wen_o  = 1'b0;
        periph_id_o   = '0;
        if (state_q == RESP) begin
            done_tag_o    = tag_q;
            done_status_o = status_q;
            done_cycles_o = cycles_q;
        end
        if (state_q == PROG) begin
            periph_req_o  = 1'b1;
            periph_add_o  = RegBase + (32'(k_q) << 2);
            periph_data_o = regs_q[k_q];
            periph_be_o   = 4'hF;
        end else if (state_q == TRIG) begin
            periph_req_o  = 1'b1;
            periph_add_o  = TrigAddr;
            periph_be_o   = 4'hF;
        end
    end

endmodule

// File: tb/tb_snax_mac_job_seq.sv
// Directed bench for snax_mac_job_seq with NumRegs=8, RegBase=0x40, TrigAddr=0x00.
// Covers both builds: with SNAX_MAC_SEQ_TIMEOUT_EN the last job times out after 16 cycles.
module tb_snax_mac_job_seq;

    logic          clk;
    logic          rst_n;
    logic          job_valid;
    logic          job_ready;
    logic [255:0]  job_regs;
    logic [7:0]    job_tag;
    logic          done_valid;
    logic          done_ready;
    logic [7:0]    done_tag;
    logic [1:0]    done_status;
    logic [31:0]   done_cycles;
    logic          req;
    logic          gnt;
    logic [31:0]   add;
    logic          wen;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [4:0]    pid;
    logic          r_valid;
    logic          evt;
    logic          busy;

    int errors = 0;
    int checks = 0;

    snax_mac_job_seq #(
        .DataWidth(32), .NumRegs(8), .RegBase(32'h40), .TrigAddr(32'h00),
        .IdWidth(5), .TimeoutCycles(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .job_valid_i(job_valid), .job_ready_o(job_ready),
        .job_regs_i(job_regs), .job_tag_i(job_tag),
        .done_valid_o(done_valid), .done_ready_i(done_ready),
        .done_tag_o(done_tag), .done_status_o(done_status), .done_cycles_o(done_cycles),
        .periph_req_o(req), .periph_gnt_i(gnt), .periph_add_o(add),
        .periph_wen_o(wen), .periph_be_o(be), .periph_data_o(wdata),
        .periph_id_o(pid), .periph_r_valid_i(r_valid),
        .evt_i(evt), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_regs(input logic [31:0] base);
        for (int k = 0; k < 8; k++) job_regs[k*32 +: 32] = base + 32'(k);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_job_ready"},  32'(job_ready), 32'd1);
        chk({tag, "_busy"},       32'(busy), 32'd0);
        chk({tag, "_done_valid"}, 32'(done_valid), 32'd0);
        chk({tag, "_done_tag"},   32'(done_tag), 32'd0);
        chk({tag, "_done_status"},32'(done_status), 32'd0);
        chk({tag, "_done_cycles"},done_cycles, 32'd0);
        chk({tag, "_req"},        32'(req), 32'd0);
        chk({tag, "_add"},        add, 32'd0);
        chk({tag, "_data"},       wdata, 32'd0);
        chk({tag, "_be"},         32'(be), 32'd0);
        chk({tag, "_wen"},        32'(wen), 32'd0);
        chk({tag, "_id"},         32'(pid), 32'd0);
    endtask

    // Called one negedge after acceptance; returns at the first WAIT cycle.
    task automatic prog_and_trig(input logic [31:0] base, input int stall_idx,
                                 input int stall_n, input int evt_idx);
        for (int i = 0; i < 8; i++) begin
            if (i == stall_idx) begin
                gnt = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    chk("stall_req",  32'(req), 32'd1);
                    chk("stall_add",  add, 32'h40 + 32'(4*i));
                    chk("stall_data", wdata, base + 32'(i));
                    @(negedge clk);
                end
            end
            gnt = 1'b1;
            evt = (i == evt_idx);
            chk("wr_req",  32'(req), 32'd1);
            chk("wr_add",  add, 32'h40 + 32'(4*i));
            chk("wr_data", wdata, base + 32'(i));
            chk("wr_be",   32'(be), 32'hF);
            chk("wr_ready",32'(job_ready), 32'd0);
            @(negedge clk);
        end
        evt = 1'b1;
        chk("trig_req",  32'(req), 32'd1);
        chk("trig_add",  add, 32'h00);
        chk("trig_data", wdata, 32'd0);
        chk("trig_busy", 32'(busy), 32'd1);
        @(negedge clk);
        evt = 1'b0;
        gnt = 1'b0;
        chk("wait_req",   32'(req), 32'd0);
        chk("wait_be",    32'(be), 32'd0);
        chk("wait_valid", 32'(done_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; job_valid = 1'b0; job_tag = 8'h00; done_ready = 1'b0;
        gnt = 1'b0; evt = 1'b0; r_valid = 1'b0;
        set_regs(32'd0);
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Job A: regs 1..8, tag 0x5A, stray evt during PROG/TRIG, evt 10 cycles after trigger gnt.
        set_regs(32'd1); job_tag = 8'h5A; job_valid = 1'b1;
        chk("a_accept_ready", 32'(job_ready), 32'd1);
        @(negedge clk);
        job_valid = 1'b0;
        prog_and_trig(32'd1, -1, 0, 3);
        for (int i = 0; i < 9; i++) begin
            chk("a_wait_valid", 32'(done_valid), 32'd0);
            @(negedge clk);
        end
        evt = 1'b1;
        @(negedge clk);
        evt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("a_resp_valid",  32'(done_valid), 32'd1);
            chk("a_resp_tag",    32'(done_tag), 32'h5A);
            chk("a_resp_status", 32'(done_status), 32'd0);
            chk("a_resp_cycles", done_cycles, 32'd10);
            chk("a_resp_ready",  32'(job_ready), 32'd0);
            @(negedge clk);
        end
        done_ready = 1'b1;
        chk("a_hs_valid", 32'(done_valid), 32'd1);
        chk("a_hs_ready", 32'(job_ready), 32'd0);
        @(negedge clk);
        done_ready = 1'b0;
        chk("a_post_valid", 32'(done_valid), 32'd0);
        chk("a_post_ready", 32'(job_ready), 32'd1);
        chk("a_post_busy",  32'(busy), 32'd0);

        // Job B: gnt withheld 3 cycles on write 2; job C presented during WAIT.
        set_regs(32'd1); job_tag = 8'h33; job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        prog_and_trig(32'd1, 2, 3, -1);
        set_regs(32'h1000_0000); job_tag = 8'hC3; job_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("b_wait_ready", 32'(job_ready), 32'd0);
            chk("b_wait_busy",  32'(busy), 32'd1);
            chk("b_wait_req",   32'(req), 32'd0);
            @(negedge clk);
        end
        evt = 1'b1;
        @(negedge clk);
        evt = 1'b0;
        chk("b_resp_valid",  32'(done_valid), 32'd1);
        chk("b_resp_tag",    32'(done_tag), 32'h33);
        chk("b_resp_cycles", done_cycles, 32'd5);
        chk("b_resp_ready",  32'(job_ready), 32'd0);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        chk("c_idle_ready", 32'(job_ready), 32'd1);
        chk("c_idle_req",   32'(req), 32'd0);
        chk("c_idle_valid", 32'(done_valid), 32'd0);
        @(negedge clk);
        job_valid = 1'b0;

        // Job C: four writes then asynchronous reset during write 4.
        gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("c_wr_add",  add, 32'h40 + 32'(4*i));
            chk("c_wr_data", wdata, 32'h1000_0000 + 32'(i));
            @(negedge clk);
        end
        chk("c_wr4_add",  add, 32'h50);
        chk("c_wr4_data", wdata, 32'h1000_0004);
        #1 rst_n = 1'b0;
        #1;
        chk_idle_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        gnt = 1'b0;
        @(negedge clk);
        chk_idle_outputs("after_abort");

        // Job D: restarts at 0x40; watchdog behaviour depends on the build.
        set_regs(32'h0000_0D00); job_tag = 8'h77; job_valid = 1'b1;
        chk("d_accept_ready", 32'(job_ready), 32'd1);
        @(negedge clk);
        job_valid = 1'b0;
        prog_and_trig(32'h0000_0D00, 5, 1, -1);
`ifdef SNAX_MAC_SEQ_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            chk("d_wait_valid", 32'(done_valid), 32'd0);
            @(negedge clk);
        end
        chk("d_to_valid",  32'(done_valid), 32'd1);
        chk("d_to_status", 32'(done_status), 32'd1);
        chk("d_to_cycles", done_cycles, 32'd16);
        evt = 1'b1;
        @(negedge clk);
        evt = 1'b0;
        chk("d_late_valid",  32'(done_valid), 32'd1);
        chk("d_late_status", 32'(done_status), 32'd1);
        chk("d_late_cycles", done_cycles, 32'd16);
        chk("d_late_tag",    32'(done_tag), 32'h77);
`else
        for (int i = 0; i < 20; i++) begin
            chk("d_wait_valid", 32'(done_valid), 32'd0);
            @(negedge clk);
        end
        evt = 1'b1;
        @(negedge clk);
        evt = 1'b0;
        chk("d_resp_valid",  32'(done_valid), 32'd1);
        chk("d_resp_status", 32'(done_status), 32'd0);
        chk("d_resp_cycles", done_cycles, 32'd21);
        chk("d_resp_tag",    32'(done_tag), 32'h77);
`endif
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        chk_idle_outputs("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
